// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and default PC parameters.
package fetch_pkg;

   typedef enum logic [1:0] {
      StBoot = 2'd0,
      StRun  = 2'd1,
      StHalt = 2'd2
   } fetch_state_e;

   localparam logic [31:0] FETCH_RESET_PC = 32'h0040_0000;
   localparam int unsigned FETCH_PC_STEP  = 4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: redirect load has priority over increment, otherwise holds.
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter int unsigned    DW       = 32,
   parameter logic [DW-1:0]  RESET_PC = DW'(FETCH_RESET_PC),
   parameter int unsigned    PC_STEP  = FETCH_PC_STEP
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [DW-1:0] load_pc,
   input  logic          inc,
   output logic [DW-1:0] pc
);

   logic [DW-1:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_pc;
      end else if (inc) begin
         // Wrap past the top of the address space is intentional and silent.
         pc_d = pc_q + DW'(PC_STEP);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage sharing one memory port between fetch and execute stores.
// Optional perf counters (fetch_count_o, stall_count_o) enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int unsigned    DW       = 32,
   parameter logic [DW-1:0]  RESET_PC = DW'(FETCH_RESET_PC),
   parameter int unsigned    PC_STEP  = FETCH_PC_STEP
) (
   input  logic          clk,
   input  logic          reset,
   output logic [DW-1:0] Address_o,
   output logic          Write_Enable_o,
   output logic [DW-1:0] Write_Data_o,
   input  logic [DW-1:0] Instruction_i,
   input  logic          store_req_i,
   input  logic [DW-1:0] store_addr_i,
   input  logic [DW-1:0] store_data_i,
   output logic          store_ack_o,
   input  logic          redirect_i,
   input  logic [DW-1:0] redirect_pc_i,
   input  logic          halt_i,
   output logic [DW-1:0] instr_o,
   output logic [DW-1:0] pc_o,
   output logic          instr_valid_o,
   input  logic          instr_ready_i
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]   fetch_count_o,
   output logic [31:0]   stall_count_o
`endif
);

   fetch_state_e  state_q, state_d;
   logic [DW-1:0] pc;
   logic [DW-1:0] ir_q;
   logic [DW-1:0] ir_pc_q;
   logic          valid_q;
   logic          store_go;
   logic          fetch_ok;

   fetch_pc_reg #(
      .DW       (DW),
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc_reg (
      .clk     (clk),
      .reset   (reset),
      .load    (redirect_i),
      .load_pc (redirect_pc_i),
      .inc     (fetch_ok),
      .pc      (pc)
   );

   // Stores are suppressed while reset is asserted so memory is never written then.
   assign store_go = store_req_i & reset;

   assign fetch_ok = (state_q == StRun) & ~store_req_i & ~halt_i & ~redirect_i &
                     (~valid_q | instr_ready_i);

   always_comb begin
      Address_o      = pc;
      Write_Enable_o = 1'b0;
      Write_Data_o   = '0;
      store_ack_o    = 1'b0;
      if (store_go) begin
         Address_o      = store_addr_i;
         Write_Enable_o = 1'b1;
         Write_Data_o   = store_data_i;
         store_ack_o    = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StBoot:  state_d = StRun;
         StRun:   if (halt_i && !redirect_i) state_d = StHalt;
         StHalt:  if (redirect_i || !halt_i) state_d = StRun;
         default: state_d = StBoot;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StBoot;
      end else begin
         state_q <= state_d;
      end
   end

   // Redirect flushes the IR even when decode is ready in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ir_q    <= '0;
         ir_pc_q <= '0;
         valid_q <= 1'b0;
      end else if (redirect_i) begin
         valid_q <= 1'b0;
      end else if (fetch_ok) begin
         ir_q    <= Instruction_i;
         ir_pc_q <= pc;
         valid_q <= 1'b1;
      end else if (valid_q && instr_ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign instr_o       = ir_q;
   assign pc_o          = ir_pc_q;
   assign instr_valid_o = valid_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count_q;
   logic [31:0] stall_count_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_count_q <= '0;
         stall_count_q <= '0;
      end else begin
         if (fetch_ok) begin
            fetch_count_q <= fetch_count_q + 32'd1;
         end
         if ((state_q == StRun) && !fetch_ok && !halt_i) begin
            stall_count_q <= stall_count_q + 32'd1;
         end
      end
   end

   assign fetch_count_o = fetch_count_q;
   assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table plus randomized run against a
// behavioural model of the fetch rules. Perf counters are checked when FETCH_PERF_CNT_EN is set.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam int MODE_BOOT = 0;
   localparam int MODE_RUN  = 1;
   localparam int MODE_HALT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Address_o;
   logic        Write_Enable_o;
   logic [31:0] Write_Data_o;
   logic [31:0] Instruction_i;
   logic        store_req_i;
   logic [31:0] store_addr_i;
   logic [31:0] store_data_i;
   logic        store_ack_o;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        halt_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        instr_valid_o;
   logic        instr_ready_i;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count_o;
   logic [31:0] stall_count_o;
`endif

   logic [31:0] mem_key = 32'h0;

   fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .Address_o      (Address_o),
      .Write_Enable_o (Write_Enable_o),
      .Write_Data_o   (Write_Data_o),
      .Instruction_i  (Instruction_i),
      .store_req_i    (store_req_i),
      .store_addr_i   (store_addr_i),
      .store_data_i   (store_data_i),
      .store_ack_o    (store_ack_o),
      .redirect_i     (redirect_i),
      .redirect_pc_i  (redirect_pc_i),
      .halt_i         (halt_i),
      .instr_o        (instr_o),
      .pc_o           (pc_o),
      .instr_valid_o  (instr_valid_o),
      .instr_ready_i  (instr_ready_i)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count_o  (fetch_count_o),
      .stall_count_o  (stall_count_o)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: the word read back is a keyed function of the address.
   assign Instruction_i = Address_o ^ mem_key;

   int errors = 0;
   int checks = 0;

   // Behavioural model of the stage.
   int          m_mode;
   logic [31:0] m_pc, m_ir, m_pco, m_fc, m_sc;
   logic        m_valid;

   typedef struct {
      logic        rst;
      logic        sreq;
      logic [31:0] saddr;
      logic [31:0] sdata;
      logic        redir;
      logic [31:0] rpc;
      logic        halt;
      logic        ready;
      logic [31:0] e_addr;
      logic        e_we;
      logic        e_valid;
      logic [31:0] e_pco;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic void mk(input logic rst, input logic sreq, input logic [31:0] saddr,
                              input logic [31:0] sdata, input logic redir,
                              input logic [31:0] rpc, input logic halt, input logic ready,
                              input logic [31:0] e_addr, input logic e_we, input logic e_valid,
                              input logic [31:0] e_pco);
      vec_t v;
      v = '{rst, sreq, saddr, sdata, redir, rpc, halt, ready, e_addr, e_we, e_valid, e_pco};
      tv.push_back(v);
   endfunction

   task automatic set_inputs(input logic rst, input logic sreq, input logic [31:0] saddr,
                             input logic [31:0] sdata, input logic redir,
                             input logic [31:0] rpc, input logic halt, input logic ready);
      reset         = rst;
      store_req_i   = sreq;
      store_addr_i  = saddr;
      store_data_i  = sdata;
      redirect_i    = redir;
      redirect_pc_i = rpc;
      halt_i        = halt;
      instr_ready_i = ready;
   endtask

   // Mid-cycle: check the memory port against the model, then advance the model.
   task automatic half_a();
      logic st, fok;
      @(negedge clk);
      st = reset && store_req_i;
      chk("addr", Address_o, st ? store_addr_i : m_pc);
      chk("we", {31'd0, Write_Enable_o}, {31'd0, st});
      chk("ack", {31'd0, store_ack_o}, {31'd0, st});
      chk("wdata", Write_Data_o, st ? store_data_i : 32'd0);
      fok = reset && (m_mode == MODE_RUN) && !store_req_i && !halt_i && !redirect_i &&
            (!m_valid || instr_ready_i);
      if (!reset) begin
         m_pc = RST_PC; m_mode = MODE_BOOT; m_ir = 0; m_pco = 0; m_valid = 0;
         m_fc = 0; m_sc = 0;
      end else begin
         if (fok) m_fc = m_fc + 1;
         if (m_mode == MODE_RUN && !fok && !halt_i) m_sc = m_sc + 1;
         if (redirect_i) m_valid = 0;
         else if (fok) begin
            m_ir = m_pc ^ mem_key; m_pco = m_pc; m_valid = 1;
         end else if (m_valid && instr_ready_i) m_valid = 0;
         if (redirect_i) m_pc = redirect_pc_i;
         else if (fok) m_pc = m_pc + 32'd4;
         case (m_mode)
            MODE_BOOT: m_mode = MODE_RUN;
            MODE_RUN:  if (halt_i && !redirect_i) m_mode = MODE_HALT;
            default:   if (redirect_i || !halt_i) m_mode = MODE_RUN;
         endcase
      end
   endtask

   // After the edge: check registered outputs against the model.
   task automatic half_b();
      @(posedge clk);
      #1;
      chk("valid", {31'd0, instr_valid_o}, {31'd0, m_valid});
      chk("pc_o", pc_o, m_pco);
      chk("instr", instr_o, m_ir);
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count_o, m_fc);
      chk("stall_count", stall_count_o, m_sc);
`endif
   endtask

   initial begin
      set_inputs(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      m_pc = RST_PC; m_mode = MODE_BOOT; m_ir = 0; m_pco = 0; m_valid = 0; m_fc = 0; m_sc = 0;

      // rst sreq saddr sdata redir rpc halt ready | addr we valid pc_o (instr == pc_o here)
      mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0000, 0, 0, 32'h0);
      mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0000, 0, 0, 32'h0);
      mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0000, 0, 1, 32'h0040_0000);
      mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0004, 0, 1, 32'h0040_0004);
      mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0008, 0, 1, 32'h0040_0004);
      mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0008, 0, 1, 32'h0040_0004);
      mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0008, 0, 1, 32'h0040_0004);
      mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0008, 0, 1, 32'h0040_0008);
      mk(1, 1, 32'h1001_0000, 32'hDEAD_BEEF, 0, 0, 0, 1, 32'h1001_0000, 1, 0, 32'h0040_0008);
      mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0040_000C, 0, 1, 32'h0040_000C);
      mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0010, 0, 1, 32'h0040_000C);
      mk(1, 1, 32'h1001_0004, 32'h1234_5678, 1, 32'h0040_0100, 0, 0,
         32'h1001_0004, 1, 0, 32'h0040_000C);
      mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0100, 0, 1, 32'h0040_0100);
      mk(1, 0, 0, 0, 0, 0, 1, 1, 32'h0040_0104, 0, 0, 32'h0040_0100);
      mk(1, 0, 0, 0, 0, 0, 1, 1, 32'h0040_0104, 0, 0, 32'h0040_0100);
      mk(1, 0, 0, 0, 1, 32'h0040_0200, 1, 1, 32'h0040_0104, 0, 0, 32'h0040_0100);
      mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0200, 0, 1, 32'h0040_0200);
      mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0204, 0, 1, 32'h0040_0200);
      mk(0, 1, 32'h1001_0000, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'h0040_0204, 0, 0, 32'h0);
      mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0000, 0, 0, 32'h0);
      mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0000, 0, 1, 32'h0040_0000);

      foreach (tv[i]) begin
         set_inputs(tv[i].rst, tv[i].sreq, tv[i].saddr, tv[i].sdata, tv[i].redir, tv[i].rpc,
                    tv[i].halt, tv[i].ready);
         half_a();
         chk($sformatf("vec%0d_addr", i), Address_o, tv[i].e_addr);
         chk($sformatf("vec%0d_we", i), {31'd0, Write_Enable_o}, {31'd0, tv[i].e_we});
         half_b();
         chk($sformatf("vec%0d_valid", i), {31'd0, instr_valid_o}, {31'd0, tv[i].e_valid});
         chk($sformatf("vec%0d_pc_o", i), pc_o, tv[i].e_pco);
         chk($sformatf("vec%0d_instr", i), instr_o, tv[i].e_pco);
      end

      // Randomized run with keyed memory contents, occasional resets and wrap-region redirects.
      mem_key = $urandom | 32'h1;
      halt_i  = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         logic h;
         logic [31:0] r;
         h = halt_i;
         if ($urandom_range(0, 7) == 0) h = ~h;
         r = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF0;
         set_inputs($urandom_range(0, 99) != 0, $urandom_range(0, 4) == 0, $urandom, $urandom,
                    $urandom_range(0, 9) == 0, r, h, $urandom_range(0, 3) != 0);
         half_a();
         half_b();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
